// File: rtl/anc_pkg.sv
// Shared types and constants for the ANC sequencing controller.
package anc_pkg;
  typedef logic signed [15:0] sample_t;

  localparam sample_t Q15_MAX     = 16'sh7FFF;
  localparam sample_t Q15_MIN     = 16'sh8000;
  localparam int      DEF_TIMEOUT = 255;

  typedef enum logic [2:0] {IDLE, SCALE, GO, WAIT, OUT} anc_ctrl_state_t;

  // Clamp a 17-bit signed value into Q1.15; overflow shows as sign/msb disagreement.
  function automatic sample_t sat16(input logic signed [16:0] v);
    if (v[16] != v[15]) return v[16] ? Q15_MIN : Q15_MAX;
    return v[15:0];
  endfunction
endpackage

// File: rtl/anc_ctrl_if.sv
// Sample-in, FIR go/done and DAC valid/ready bundle; master = controller side.
interface anc_ctrl_if;
  import anc_pkg::*;
  sample_t x_sample, e_sample;
  logic    smp_valid;
  logic    fir_go;
  sample_t fir_x, fir_a, fir_wadj;
  logic    fir_done;
  sample_t fir_sample;
  sample_t dac_sample;
  logic    dac_valid, dac_ready;

  modport master (
    input  x_sample, e_sample, smp_valid, fir_done, fir_sample, dac_ready,
    output fir_go, fir_x, fir_a, fir_wadj, dac_sample, dac_valid
  );
  modport slave (
    output x_sample, e_sample, smp_valid, fir_done, fir_sample, dac_ready,
    input  fir_go, fir_x, fir_a, fir_wadj, dac_sample, dac_valid
  );
endinterface

// File: rtl/anc_mu_scale.sv
// Combinational weight adjust: sat16((mu*e) >>> 15), truncating shift.
module anc_mu_scale
  import anc_pkg::*;
(
  input  sample_t mu,
  input  sample_t e,
  output sample_t wadj
);
  logic signed [31:0] prod;

  assign prod = mu * e;
  // Only mu = e = -32768 overflows the 16-bit result after the shift.
  assign wadj = sat16(17'(prod >>> 15));
endmodule

// File: rtl/anc_ctrl.sv
// ANC sequencer: sample -> scale mu*e -> FIR go/done -> DAC, with a one-deep
// pending slot and sticky overrun/timeout flags. Optional ANC_CTRL_FREEZE_EN adds freeze.
module anc_ctrl
  import anc_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT,
  parameter int CNT_W          = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  anc_ctrl_if.master        bus,
  input  sample_t           mu,
  input  sample_t           a_offset,
`ifdef ANC_CTRL_FREEZE_EN
  input  logic              freeze,
`endif
  input  logic              err_clr,
  output logic              busy,
  output logic              overrun,
  output logic              timeout_err
);
  anc_ctrl_state_t  state;
  sample_t          x_r, e_r, a_r, pend_x, pend_e, wadj_c;
  logic             pend_full;
  logic [CNT_W-1:0] cnt;
  logic             to_hit, ovr_hit;

  anc_mu_scale u_scale (.mu(mu), .e(e_r), .wadj(wadj_c));

  assign busy    = (state != IDLE);
  assign to_hit  = (state == WAIT) && !bus.fir_done && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign ovr_hit = bus.smp_valid && (state != IDLE) && pend_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      x_r            <= '0;
      e_r            <= '0;
      a_r            <= '0;
      pend_x         <= '0;
      pend_e         <= '0;
      pend_full      <= 1'b0;
      cnt            <= '0;
      bus.fir_go     <= 1'b0;
      bus.fir_x      <= '0;
      bus.fir_a      <= '0;
      bus.fir_wadj   <= '0;
      bus.dac_sample <= '0;
      bus.dac_valid  <= 1'b0;
      overrun        <= 1'b0;
      timeout_err    <= 1'b0;
    end else begin
      // Set beats clear when an error event lands on the err_clr cycle.
      overrun     <= (overrun & ~err_clr) | ovr_hit;
      timeout_err <= (timeout_err & ~err_clr) | to_hit;

      if (bus.smp_valid && state != IDLE) begin
        pend_x    <= bus.x_sample;
        pend_e    <= bus.e_sample;
        pend_full <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (pend_full) begin
            x_r   <= pend_x;
            e_r   <= pend_e;
            a_r   <= a_offset;
            state <= SCALE;
            // A live strobe refills the slot just vacated, so it stays full.
            if (bus.smp_valid) begin
              pend_x <= bus.x_sample;
              pend_e <= bus.e_sample;
            end else begin
              pend_full <= 1'b0;
            end
          end else if (bus.smp_valid) begin
            x_r   <= bus.x_sample;
            e_r   <= bus.e_sample;
            a_r   <= a_offset;
            state <= SCALE;
          end
        end
        SCALE: begin
          bus.fir_x  <= x_r;
          bus.fir_a  <= a_r;
`ifdef ANC_CTRL_FREEZE_EN
          bus.fir_wadj <= freeze ? '0 : wadj_c;
`else
          bus.fir_wadj <= wadj_c;
`endif
          bus.fir_go <= 1'b1;
          state      <= GO;
        end
        GO: begin
          bus.fir_go <= 1'b0;
          cnt        <= '0;
          state      <= WAIT;
        end
        WAIT: begin
          cnt <= cnt + 1'b1;
          if (bus.fir_done) begin
            bus.dac_sample <= bus.fir_sample;
            bus.dac_valid  <= 1'b1;
            state          <= OUT;
          end else if (to_hit) begin
            bus.dac_sample <= '0;
            bus.dac_valid  <= 1'b1;
            state          <= OUT;
          end
        end
        OUT: begin
          if (bus.dac_ready) begin
            bus.dac_valid <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/anc_ctrl.md
Name: anc_ctrl

Overview:
- Sequencing controller that drives the adaptive FIR engine, i.e. the initiator side of its fir_go/done handshake.
- Accepts paired reference/error mic samples from the ADC front end and computes weight_adjust = mu*e in Q1.15.
- Presents x/a/weight_adjust and pulses fir_go, then waits for done and forwards the anti-noise sample to the DAC over valid/ready.
- Holds a one-deep pending slot and sticky overrun/timeout flags.

Parameters:
TIMEOUT_CYCLES, 255, cycles allowed from fir_go to fir_done before abort (FIR nominal is TAPS+7).
CNT_W, 8, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
x_sample  in  16  signed reference-mic sample, Q1.15
e_sample  in  16  signed error-mic sample, Q1.15
smp_valid  in  1  one-cycle strobe; x_sample and e_sample are valid together
mu  in  16  signed step size, Q1.15, quasi-static
a_offset  in  16  signed accumulator preload passed to the FIR
fir_go  out  1  one-cycle start pulse to the FIR
fir_x  out  16  x_in to the FIR
fir_a  out  16  a_in to the FIR
fir_wadj  out  16  weight_adjust to the FIR
fir_done  in  1  FIR completion pulse
fir_sample  in  16  FIR out_sample; valid when fir_done=1
dac_sample  out  16  anti-noise sample
dac_valid  out  1  dac_sample valid
dac_ready  in  1  DAC accepts
busy  out  1  high whenever state != IDLE
overrun  out  1  sticky: a pending sample was overwritten
timeout_err  out  1  sticky: fir_done was missing
err_clr  in  1  clears both sticky flags

Behaviour:
- Reset values: all outputs 0, state IDLE, pending slot empty, counter 0. Reset is asynchronous and takes effect mid-operation; fir_go deasserts immediately.
- State machine: IDLE -> SCALE -> GO -> WAIT -> OUT -> IDLE.
- IDLE:
  - If the pending slot is full, take it and mark the slot empty.
  - Else if smp_valid=1, take the live inputs.
  - Latch x, e and a_offset, then go to SCALE.
- SCALE: fir_wadj <= sat16((mu*e) >>> 15), using arithmetic shift with truncation.
  - The product is a full 32-bit signed value.
  - Saturate to [-32768, 32767]; mu=e=-32768 gives 32767.
- GO:
  - fir_go=1 for exactly one cycle; clear the counter; go to WAIT.
  - Latency: accepted smp_valid at cycle N gives fir_go at cycle N+2.
- fir_x, fir_a and fir_wadj stay stable from SCALE exit until the next sample's SCALE.
- WAIT:
  - Counter increments each cycle.
  - On fir_done=1: register dac_sample <= fir_sample, go to OUT.
  - If the counter reaches TIMEOUT_CYCLES with no done: set timeout_err, dac_sample <= 0 (mute), go to OUT.
  - fir_done outside WAIT is ignored, including a late done after a timeout.
- OUT:
  - dac_valid=1; dac_sample is held while dac_ready=0.
  - On dac_valid&&dac_ready: dac_valid <= 0 next cycle, go to IDLE.
  - No combinational path from dac_ready to dac_valid.
- smp_valid while state != IDLE:
  - Slot empty: store the sample.
  - Slot full: overwrite with the newer sample and set overrun.
- smp_valid in IDLE while the slot is full: the pending sample is processed and the new one goes into the slot. No overrun is flagged.
- err_clr coinciding with a new error event: set wins.

Optional Feature:
- Macro ANC_CTRL_FREEZE_EN.
- Defined:
  - Adds input freeze (1 bit).
  - While freeze=1 at SCALE, fir_wadj <= 0, so adaptation is frozen and the output path is unaffected.
  - freeze is sampled only in SCALE.
- Undefined: no freeze port; fir_wadj always equals the scaled mu*e.

Decomposition:
- Shared package anc_pkg holds:
  - sample_t (signed 16b);
  - Q15_MAX=32767 and Q15_MIN=-32768;
  - the state enum anc_ctrl_state_t {IDLE, SCALE, GO, WAIT, OUT};
  - DEF_TIMEOUT=255.
- One sub-module, anc_mu_scale: wraps the team bw_mult 16x16 multiplier and the saturate block (17->16 after the >>>15) to produce sat16((mu*e)>>>15) combinationally; anc_ctrl registers its output in SCALE.

Test Plan:
- Basic flow: mu=16384, e=8192, x=1000, a_offset=0, smp_valid at cycle 0 -> fir_go at cycle 2 with fir_wadj=4096, fir_x=1000. The model returns done + 1234 after 135 cycles -> dac_valid with dac_sample=1234; dac_ready=1 -> IDLE.
- Saturation: mu=-32768, e=-32768 -> fir_wadj=32767. mu=32767, e=-32768 -> fir_wadj=-32767.
- Overrun: three smp_valid strobes during WAIT (x=1,2,3) -> overrun=1; the next FIR run uses x=3; err_clr for one cycle -> overrun=0.
- Timeout: the FIR model never asserts done -> after 255 WAIT cycles timeout_err=1 and dac_sample=0 valid. A late done is ignored; the next sample proceeds normally.
- Backpressure: dac_ready=0 for 10 cycles in OUT -> dac_valid and dac_sample stay stable; reset asserted mid-WAIT -> all outputs 0 asynchronously, state IDLE.
- ANC_CTRL_FREEZE_EN: freeze=1, mu=16384, e=8192 -> fir_wadj=0; with freeze=0 -> 4096.
